reg_write_arbiter: RTL and testbench

Arbitrates write access to the shared 5-entry configuration register bank (output enables, PWM enables, PWM duty) between two requesters. Port A is the SPI peripheral's decoded write path; port B is an on-chip sequencer/test engine. The block owns the register bank and drives the register outputs consumed by the PWM peripheral. Fairness is round-robin; each requester uses a 4-phase req/gnt handshake.

---
 rtl/reg_write_arbiter.sv | 133 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the shared configuration register bank.
// Two requesters use a 4-phase req/gnt handshake; the granted write commits in CAPT.

module reg_write_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              err_addr,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StCapt, StAck} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;  // 0: port A, 1: port B
    logic                prio_q, prio_d;    // port that wins a tie
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                a_gnt_q, a_gnt_d;
    logic                b_gnt_q, b_gnt_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic pick_b;
    logic owner_req;

    assign pick_b    = b_req && (!a_req || prio_q);
    assign owner_req = owner_q ? b_req : a_req;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        data_d  = data_q;
        a_gnt_d = a_gnt_q;
        b_gnt_d = b_gnt_q;
        err_d   = 1'b0;
        regs_d  = regs_q;

        case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = pick_b;
                    addr_d  = pick_b ? b_addr : a_addr;
                    data_d  = pick_b ? b_data : a_data;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        regs_d[i] = data_q;
                    end
                end
                err_d   = (addr_q >= ADDR_W'(NUM_REGS));
                a_gnt_d = !owner_q;
                b_gnt_d = owner_q;
                state_d = StAck;
            end
            StAck: begin
                if (!owner_req) begin
                    a_gnt_d = 1'b0;
                    b_gnt_d = 1'b0;
                    prio_d  = !owner_q;
                    state_d = StIdle;
                end
            end
            default: begin
                a_gnt_d = 1'b0;
                b_gnt_d = 1'b0;
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end

    assign a_gnt           = a_gnt_q;
    assign b_gnt           = b_gnt_q;
    assign err_addr        = err_q;
    assign busy            = busy_q;
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: expected grants are queued as requests are
// posted and compared against the register bank model when each grant appears.

module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, b_req;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_gnt, b_gnt;
    logic [7:0] r0, r1, r2, r3, r4;
    logic       err_addr, busy;

    reg_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_req           (a_req),
        .a_addr          (a_addr),
        .a_data          (a_data),
        .a_gnt           (a_gnt),
        .b_req           (b_req),
        .b_addr          (b_addr),
        .b_data          (b_data),
        .b_gnt           (b_gnt),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .err_addr        (err_addr),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         port;
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       pend_a[$];
    txn_t       pend_b[$];
    txn_t       exp_q[$];
    logic [7:0] model [5];
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [39:0] regs_now();
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [39:0] regs_model();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic add(input bit port, input logic [6:0] addr, input logic [7:0] data);
        txn_t t;
        t.port = port;
        t.addr = addr;
        t.data = data;
        if (port) pend_b.push_back(t);
        else      pend_a.push_back(t);
        exp_q.push_back(t);
    endtask

    task automatic load(input bit port);
        txn_t t;
        if (!port && pend_a.size() > 0) begin
            t = pend_a.pop_front();
            a_req = 1'b1; a_addr = t.addr; a_data = t.data;
        end else if (port && pend_b.size() > 0) begin
            t = pend_b.pop_front();
            b_req = 1'b1; b_addr = t.addr; b_data = t.data;
        end
    endtask

    // Serve n grants; every grant is expected exactly 2 cycles after the requests
    // are visible in IDLE (initial post, or the cycle the previous gnt dropped).
    task automatic run(input int n);
        txn_t e;
        int   cyc;
        bit   gport;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(a_gnt || b_gnt) && cyc < 20);
            if (!(a_gnt || b_gnt)) begin
                check("grant_timeout", 40'd0, 40'd1);
                return;
            end
            e = exp_q.pop_front();
            gport = b_gnt;
            check("grant_latency", 40'(cyc), 40'd2);
            check("grant_owner", {39'd0, b_gnt}, {39'd0, e.port});
            check("gnt_exclusive", {39'd0, a_gnt && b_gnt}, 40'd0);
            check("busy_in_ack", {39'd0, busy}, 40'd1);
            check("err_pulse", {39'd0, err_addr}, {39'd0, e.addr >= 7'd5});
            if (e.addr < 7'd5) model[e.addr[2:0]] = e.data;
            check("regs_at_gnt", regs_now(), regs_model());
            if (gport) b_req = 1'b0;
            else       a_req = 1'b0;
            @(negedge clk);
            check("gnt_release", {38'd0, a_gnt, b_gnt}, 40'd0);
            check("busy_idle", {39'd0, busy}, 40'd0);
            check("err_not_sticky", {39'd0, err_addr}, 40'd0);
            load(gport);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_addr = '0; b_data = '0;

        // Reset held with a pending A request
        add(1'b0, 7'h04, 8'h5A);
        load(1'b0);
        repeat (3) @(negedge clk);
        check("reset_regs", regs_now(), 40'd0);
        check("reset_gnts", {38'd0, a_gnt, b_gnt}, 40'd0);
        check("reset_busy", {39'd0, busy}, 40'd0);
        check("reset_err", {39'd0, err_addr}, 40'd0);
        rst_n = 1'b1;
        run(1);

        // Single A write to duty cycle
        add(1'b0, 7'h04, 8'h80);
        load(1'b0);
        run(1);
        check("duty_0x80", {32'd0, r4}, 40'h80);

        // B writes an unimplemented address
        add(1'b1, 7'h05, 8'hAA);
        load(1'b1);
        run(1);

        // Simultaneous requests, pointer now at A
        add(1'b0, 7'h00, 8'hFF);
        add(1'b1, 7'h01, 8'h0F);
        load(1'b0);
        load(1'b1);
        run(2);
        check("out_regs", {24'd0, r1, r0}, 40'h0FFF);

        // B drops req while still in CAPT: write commits, gnt is a one-cycle pulse
        b_req = 1'b1; b_addr = 7'h03; b_data = 8'h3C;
        @(negedge clk);
        b_req = 1'b0;
        @(negedge clk);
        model[3] = 8'h3C;
        check("capt_drop_gnt", {38'd0, a_gnt, b_gnt}, 40'd1);
        check("capt_drop_regs", regs_now(), regs_model());
        @(negedge clk);
        check("capt_drop_pulse", {38'd0, a_gnt, b_gnt}, 40'd0);

        // A re-requests continuously with B pending: grants alternate A,B,A,B
        add(1'b0, 7'h02, 8'h11);
        add(1'b1, 7'h00, 8'h01);
        add(1'b0, 7'h03, 8'h22);
        add(1'b1, 7'h01, 8'h02);
        load(1'b0);
        load(1'b1);
        run(4);
        check("queue_drained", 40'(exp_q.size()), 40'd0);

        // Asynchronous reset while in ACK after writing 0x02 <= 0x33
        a_req = 1'b1; a_addr = 7'h02; a_data = 8'h33;
        repeat (2) @(negedge clk);
        check("pre_reset_gnt", {39'd0, a_gnt}, 40'd1);
        check("pre_reset_pwm", {32'd0, r2}, 40'h33);
        @(negedge clk);
        check("pre_reset_busy", {39'd0, busy}, 40'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_regs", regs_now(), 40'd0);
        check("async_reset_gnts", {38'd0, a_gnt, b_gnt}, 40'd0);
        check("async_reset_busy", {39'd0, busy}, 40'd0);
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {38'd0, busy, a_gnt || b_gnt}, 40'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
